// File: rtl/keypad_entry_if.sv
// Bundle between the keypad driver (master) and keypad_entry_buffer (slave).
// cambio_digito is a one-cycle strobe with no ready: digito is valid only in that cycle and the slave never stalls the driver.
interface keypad_entry_if #(
  parameter int N_DIGITS = 4,
  parameter int OUT_W    = 14
);
  logic [4:0]            digito;
  logic                  cambio_digito;
  logic [4*N_DIGITS-1:0] valor;
  logic [2:0]            cuenta;
  logic [OUT_W-1:0]      dato;
  logic                  dato_valid;
  logic                  busy;
  logic                  overflow;

  modport master (
    output digito, cambio_digito,
    input  valor, cuenta, dato, dato_valid, busy, overflow
  );

  modport slave (
    input  digito, cambio_digito,
    output valor, cuenta, dato, dato_valid, busy, overflow
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Collects keypad digits into a right-aligned BCD entry and converts it to binary on enter.
// Optional feature macro: ENTRY_BACKSPACE_EN (key 0xA removes the last digit).
module keypad_entry_buffer #(
  parameter int N_DIGITS = 4,
  parameter int OUT_W    = 14
) (
  input  logic           clk,
  input  logic           rst,
  keypad_entry_if.slave  kp,
  output logic           state_dbg_o
);
  localparam int VW = 4 * N_DIGITS;
  localparam int MW = OUT_W + 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    valor_q, valor_d;
  logic [VW-1:0]    conv_q, conv_d;
  logic [2:0]       cuenta_q, cuenta_d;
  logic [2:0]       idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] dato_q, dato_d;
  logic             dato_valid_q, dato_valid_d;
  logic             overflow_q, overflow_d;

  logic [3:0]       cur_digit;
  logic [MW-1:0]    acc_ext;
  logic [OUT_W-1:0] acc_step;

  // Digit selected by the conversion index, MSD first.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == 3'(i)) cur_digit = conv_q[4*i +: 4];
    end
  end

  // acc*10 + digit as shift-add in a widened word, then truncated.
  always_comb begin
    acc_ext  = MW'(acc_q);
    acc_step = OUT_W'((acc_ext << 3) + (acc_ext << 1) + MW'(cur_digit));
  end

  always_comb begin
    state_d      = state_q;
    valor_d      = valor_q;
    conv_d       = conv_q;
    cuenta_d     = cuenta_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dato_d       = dato_q;
    dato_valid_d = 1'b0;
    overflow_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (kp.cambio_digito) begin
          if (kp.digito < 5'd10) begin
            if (cuenta_q < 3'(N_DIGITS)) begin
              valor_d  = (valor_q << 4) | VW'(kp.digito[3:0]);
              cuenta_d = cuenta_q + 3'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (kp.digito == 5'h0F) begin
            valor_d  = '0;
            cuenta_d = '0;
          end else if (kp.digito == 5'h0E) begin
            if (cuenta_q != 3'd0) begin
              conv_d  = valor_q;
              acc_d   = '0;
              idx_d   = 3'(N_DIGITS - 1);
              state_d = S_CONV;
            end
          end
`ifdef ENTRY_BACKSPACE_EN
          else if (kp.digito == 5'h0A) begin
            if (cuenta_q != 3'd0) begin
              valor_d  = valor_q >> 4;
              cuenta_d = cuenta_q - 3'd1;
            end
          end
`endif
        end
      end

      S_CONV: begin
        // Key strobes are dropped here; the displayed entry stays until completion.
        acc_d = acc_step;
        if (idx_q == 3'd0) begin
          dato_d       = acc_step;
          dato_valid_d = 1'b1;
          valor_d      = '0;
          cuenta_d     = '0;
          state_d      = S_IDLE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valor_q      <= '0;
      conv_q       <= '0;
      cuenta_q     <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      dato_q       <= '0;
      dato_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      valor_q      <= valor_d;
      conv_q       <= conv_d;
      cuenta_q     <= cuenta_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      dato_q       <= dato_d;
      dato_valid_q <= dato_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign kp.valor      = valor_q;
  assign kp.cuenta     = cuenta_q;
  assign kp.dato       = dato_q;
  assign kp.dato_valid = dato_valid_q;
  assign kp.overflow   = overflow_q;
  assign kp.busy       = (state_q == S_CONV);
  assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Self-checking bench for keypad_entry_buffer: directed key sequences plus random keys
// checked against a digit-list reference model. Honors ENTRY_BACKSPACE_EN like the design.
module tb_keypad_entry_buffer;
  localparam int N  = 4;
  localparam int W  = 14;
  localparam int VW = 4 * N;

  logic clk = 1'b0;
  logic rst;
  logic state_dbg;

  always #5 clk = ~clk;

  keypad_entry_if #(.N_DIGITS(N), .OUT_W(W)) kp ();

  keypad_entry_buffer #(.N_DIGITS(N), .OUT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .kp          (kp),
    .state_dbg_o (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  int         m_digits[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dato;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entry packed as BCD, most recent key in the low nibble.
  function automatic logic [31:0] m_valor();
    logic [31:0] v = 0;
    foreach (m_digits[i]) v = v * 16 + 32'(m_digits[i]);
    return v;
  endfunction

  // Decimal value of the entry as a sum of digit * 10^position.
  function automatic logic [31:0] m_value();
    int v = 0;
    int p = 1;
    for (int i = m_digits.size() - 1; i >= 0; i--) begin
      v += m_digits[i] * p;
      p *= 10;
    end
    return 32'(v % (1 << W));
  endfunction

  task automatic check_entry(input string tag);
    check({tag, "_valor"},  32'(kp.valor),  m_valor());
    check({tag, "_cuenta"}, 32'(kp.cuenta), 32'(m_digits.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kp.digito = 5'd16;
    kp.cambio_digito = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_digits.delete();
    exp_q.delete();
    m_dato = '0;
    check("rst_valor", 32'(kp.valor), 0);
    check("rst_cuenta", 32'(kp.cuenta), 0);
    check("rst_dato", 32'(kp.dato), 0);
    check("rst_dato_valid", 32'(kp.dato_valid), 0);
    check("rst_busy", 32'(kp.busy), 0);
    check("rst_overflow", 32'(kp.overflow), 0);
    check("rst_state", 32'(state_dbg), 0);
  endtask

  // Called at the negedge right after the enter was sampled.
  task automatic run_conv(input int drop_pct, input int rst_cycle);
    for (int i = 0; i <= N; i++) begin
      if (i > 0) @(negedge clk);
      kp.cambio_digito = 1'b0;
      if (i < N) begin
        check("conv_busy", 32'(kp.busy), 1);
        check("conv_no_valid", 32'(kp.dato_valid), 0);
        check_entry("conv_hold");
        if (i == rst_cycle) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          void'(exp_q.pop_back());
          m_digits.delete();
          m_dato = '0;
          check("abort_valor", 32'(kp.valor), 0);
          check("abort_cuenta", 32'(kp.cuenta), 0);
          check("abort_dato", 32'(kp.dato), 0);
          check("abort_busy", 32'(kp.busy), 0);
          check("abort_overflow", 32'(kp.overflow), 0);
          repeat (N + 1) begin
            check("abort_no_valid", 32'(kp.dato_valid), 0);
            @(negedge clk);
          end
          return;
        end
        if ($urandom_range(0, 99) < drop_pct) begin
          kp.digito = 5'($urandom_range(0, 17));
          kp.cambio_digito = 1'b1;
        end
      end else begin
        m_dato = exp_q.pop_front();
        m_digits.delete();
        check("done_valid", 32'(kp.dato_valid), 1);
        check("done_dato", 32'(kp.dato), 32'(m_dato));
        check("done_busy", 32'(kp.busy), 0);
        check("done_overflow", 32'(kp.overflow), 0);
        check_entry("done_clear");
      end
    end
  endtask

  task automatic press(input int k, input int drop_pct, input int rst_cycle);
    logic exp_ovf;
    logic go_conv;
    @(negedge clk);
    check("pulse_width_valid", 32'(kp.dato_valid), 0);
    check("pulse_width_ovf", 32'(kp.overflow), 0);
    check("dato_hold", 32'(kp.dato), 32'(m_dato));
    kp.digito = 5'(k);
    kp.cambio_digito = 1'b1;
    exp_ovf = 1'b0;
    go_conv = 1'b0;
    if (k < 10) begin
      if (m_digits.size() < N) m_digits.push_back(k);
      else exp_ovf = 1'b1;
    end else if (k == 15) begin
      m_digits.delete();
    end else if (k == 14) begin
      if (m_digits.size() > 0) begin
        go_conv = 1'b1;
        exp_q.push_back(W'(m_value()));
      end
    end
`ifdef ENTRY_BACKSPACE_EN
    else if (k == 10) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end
`endif
    @(negedge clk);
    kp.cambio_digito = 1'b0;
    kp.digito = 5'd16;
    check("overflow", 32'(kp.overflow), 32'(exp_ovf));
    if (go_conv) begin
      run_conv(drop_pct, rst_cycle);
    end else begin
      check("idle_busy", 32'(kp.busy), 0);
      check("idle_no_valid", 32'(kp.dato_valid), 0);
      check_entry("key");
    end
  endtask

  function automatic int rand_key();
    int r = $urandom_range(0, 99);
    int others[5] = '{11, 12, 13, 16, 17};
    if (r < 60) return $urandom_range(0, 9);
    if (r < 72) return 14;
    if (r < 77) return 15;
    if (r < 85) return 10;
    return others[$urandom_range(0, 4)];
  endfunction

  initial begin
    do_reset();

    // 1,2,3,4 then enter
    press(1, 0, -1); press(2, 0, -1); press(3, 0, -1); press(4, 0, -1);
    check("t1_valor", 32'(kp.valor), 32'h1234);
    check("t1_cuenta", 32'(kp.cuenta), 4);
    press(14, 0, -1);
    check("t1_dato", 32'(kp.dato), 1234);

    // full entry rejects fifth digit
    press(9, 0, -1); press(9, 0, -1); press(9, 0, -1); press(9, 0, -1);
    press(5, 0, -1);
    check("t2_valor", 32'(kp.valor), 32'h9999);
    press(14, 0, -1);
    check("t2_dato", 32'(kp.dato), 32'h270F);

    // leading zero, then enter on empty entry
    press(0, 0, -1); press(7, 0, -1); press(14, 0, -1);
    check("t3_dato", 32'(kp.dato), 7);
    press(14, 0, -1);
    repeat (N + 1) begin
      @(negedge clk);
      check("t3_empty_busy", 32'(kp.busy), 0);
      check("t3_empty_valid", 32'(kp.dato_valid), 0);
    end

    // backspace key
    press(5, 0, -1); press(6, 0, -1); press(10, 0, -1); press(8, 0, -1);
`ifdef ENTRY_BACKSPACE_EN
    check("t4_valor", 32'(kp.valor), 32'h0058);
    check("t4_cuenta", 32'(kp.cuenta), 2);
`else
    check("t4_valor", 32'(kp.valor), 32'h0568);
    check("t4_cuenta", 32'(kp.cuenta), 3);
`endif
    press(15, 0, -1);
    check("t4_clear", 32'(kp.valor), 0);

    // key during conversion is dropped
    press(3, 0, -1);
    press(14, 100, -1);
    check("t5_dato", 32'(kp.dato), 3);
    check("t5_valor", 32'(kp.valor), 0);

    // reset mid-conversion
    press(4, 0, -1); press(2, 0, -1);
    press(14, 0, 1);
    check("t6_dato", 32'(kp.dato), 0);

    // random traffic with idle noise cycles and dropped strobes
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        kp.digito = 5'($urandom_range(0, 17));
        kp.cambio_digito = 1'b0;
      end
      press(rand_key(), 30, ($urandom_range(0, 19) == 0) ? $urandom_range(0, N - 1) : -1);
    end

    check("final_exp_q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Downstream consumer of the keypad driver: collects key events (`digito` qualified by `cambio_digito`) into a right-aligned BCD entry of up to `N_DIGITS` decimal digits, exposes it live for the display, and on the enter key converts it to binary with a sequential multiply-add. The result is then handed to the application logic with a one-cycle valid pulse. The block runs on the same slow keypad clock as the driver.

## Interface
- `N_DIGITS`, 4: maximum digits in one entry (1..6).
- `OUT_W`, 14: binary result width; must hold 10^N_DIGITS − 1.
- `clk` input 1: system clock, same clock as the keypad driver.
- `rst` input 1: synchronous, active-high reset.
- `digito` input 5: key code; 0–9 digits, 0xA–0xF command keys, 16/17 no key.
- `cambio_digito` input 1: one-cycle pulse; `digito` is valid in that cycle.
- `valor` output 4·N_DIGITS: live BCD entry. Least-significant digit is in bits [3:0].
- `cuenta` output 3: number of digits currently entered, 0..N_DIGITS.
- `dato` output OUT_W: last converted binary value. Held until the next conversion.
- `dato_valid` output 1: one-cycle pulse when `dato` updates.
- `busy` output 1: high while converting.
- `overflow` output 1: one-cycle pulse when a digit is rejected because the entry is full.

## Operation
- States: IDLE (accepting keys) and CONV (converting). Reset goes to IDLE.
- Events are acted on only in IDLE, on cycles with `cambio_digito`=1. Other cycles are ignored.
- Key 0–9:
  - If `cuenta` < N_DIGITS: `valor` <= {valor[4·N−5:0], digit} and `cuenta`++.
  - Else: entry unchanged and `overflow` pulses.
- Key 0xF (clear): `valor` <= 0, `cuenta` <= 0.
- Key 0xA (backspace): only when ENTRY_BACKSPACE_EN is defined (see Configuration).
- Key 0xE (enter):
  - If `cuenta` = 0: ignored.
  - Else: snapshot `valor` into the internal conversion register, set acc = 0, set index = N_DIGITS−1, go to CONV.
- Keys 0xB, 0xC, 0xD, 16, 17: ignored.
- CONV, one digit per cycle, MSD first: acc <= acc·10 + bcd[index]. Multiply as (acc<<3)+(acc<<1), computed in OUT_W+4 bits, then truncated to OUT_W.
- Leading zero digits are processed like any other digit. They do not affect the result.
- After the step with index 0: `dato` <= acc result, `dato_valid` <= 1, `valor` <= 0, `cuenta` <= 0, return to IDLE.
- `cambio_digito` pulses arriving during CONV are dropped, not queued.
- `valor` holds the entered digits unchanged throughout CONV and clears only at completion.
- Reset in any state, including mid-CONV, aborts. No `dato_valid` is produced.

## Timing
- Reset values: `valor`=0, `cuenta`=0, `dato`=0, `dato_valid`=0, `busy`=0, `overflow`=0. State is IDLE.
- Digit and command keys take effect at the edge sampling `cambio_digito`. The new `valor`/`cuenta` are visible the next cycle.
- Enter sampled at edge E0:
  - `busy`=1 from after E0 through edge EN (N_DIGITS edges).
  - `dato` and `dato_valid` are registered at EN. `dato_valid` is high for exactly the cycle after EN.
  - `busy` returns to 0 in that same cycle.
- Total latency from enter sample to `dato_valid` is N_DIGITS cycles.
- `overflow` is high for exactly the one cycle after the rejecting edge.
- `dato_valid` and `overflow` are never high in the same cycle.

## Configuration
- `ENTRY_BACKSPACE_EN` defined:
  - Key 0xA with `cuenta` > 0: `valor` <= valor >> 4, `cuenta`−−.
  - With `cuenta` = 0: no effect.
- `ENTRY_BACKSPACE_EN` not defined: key 0xA is ignored like 0xB–0xD. No backspace logic is synthesized.

## Test plan
- Keys 1,2,3,4 then E (N=4) → `valor`=0x1234 and `cuenta`=4 before enter; `dato`=1234 and `dato_valid` pulse exactly 4 cycles after the enter sample; then `valor`=0, `cuenta`=0.
- Keys 9,9,9,9,5 → fifth key rejected, `overflow` pulse, `valor`=0x9999. Then E → `dato`=9999 (0x270F).
- Keys 0,7 then E → `dato`=7. E with empty entry → no `dato_valid`, `busy` stays 0.
- With ENTRY_BACKSPACE_EN: keys 5,6,A,8 → `valor`=0x0058, `cuenta`=2. Without it: `valor`=0x0568, `cuenta`=3.
- Keys 3 then E, key 6 pulsed during CONV → 6 dropped; `dato`=3 and `valor`=0 afterwards.
- Keys 4,2 then E, `rst` asserted on the second CONV cycle → no `dato_valid`; all outputs return to reset values.
